vproc_mem_responder: RTL and testbench
======================================

# vproc_mem_responder

Memory-mapped responder for the VProc-based RISC-V processor wrapper. It sits at the far end of the processor's 32-bit memory-mapped master port and answers every read and write. It provides:
- a word-organised RAM with byte enables;
- a programmable wait-state generator that drives `waitrequest`;
- a 64-bit mtime/mtimecmp timer whose compare output drives the processor `irq` input.

It is the standard test-bench memory and interrupt source for co-simulation.

## Interface
- `ADDR_WIDTH`, 12: RAM word-address bits; RAM is 2^ADDR_WIDTH x 32 bits, indexed by `address[ADDR_WIDTH+1:2]`.
- `RD_WAIT`, 1: wait cycles per read, range 1..15.
- `WR_WAIT`, 0: wait cycles per write, range 0..15.
- `TIMER_BASE`, 32'hAFFFFFE0: base of the timer register block (16 bytes, 16-byte aligned).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `nreset`  in  1  reset; asynchronous assertion, active-low.
- `address`  in  32  byte address from master; bits [1:0] ignored.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  per-byte write enables; bit n covers writedata[8n+7:8n].
- `read`  in  1  read request.
- `readdata`  out  32  read data; valid in the completion cycle of a read.
- `waitrequest`  out  1  high = transfer stalled; a transfer completes in a cycle with (`read` | `write`) & ~`waitrequest`.
- `irq`  out  1  timer interrupt, level, registered.

## Operation
- Address decode:
  - `address[31:4]` == `TIMER_BASE[31:4]` selects the timer.
  - All other addresses select the RAM; upper bits are ignored, so the RAM aliases modulo its size.
- Timer registers at word offsets 0..3: mtime[31:0], mtime[63:32], mtimecmp[31:0], mtimecmp[63:32]. They are read/write and honour `byteenable`.
- mtime increments by 1 every clock, wrapping from 2^64-1 to 0. A write completing to an mtime word replaces the enabled bytes; the increment is suppressed in that cycle.
- `irq` is registered each cycle as (mtime >= mtimecmp), unsigned 64-bit compare, using the pre-edge values.
- RAM writes affect only the enabled bytes. `byteenable` = 0 completes the transfer and changes nothing.
- Reads return the full 32-bit word regardless of `byteenable`.
- Concurrent `read` & `write`: the write is performed and the read is ignored. `readdata` holds its previous value.
- FSM states:
  - IDLE: no transfer in progress.
    - On a request with N = 0 (write with `WR_WAIT` = 0), the transfer completes in the same cycle.
    - Otherwise, load counter = N-1 and go to WAIT.
  - WAIT: counter decrements each cycle. At counter = 0, go to DONE.
  - DONE: `waitrequest` low and the transfer completes. The write is committed, or `readdata` is presented. Return to IDLE.
- Read data is fetched from RAM/timer on the last WAIT cycle into the `readdata` register.
- The master holds `address`, `writedata`, `byteenable` and request stable until completion. The block samples them only in the fetch and commit cycles.

## Timing
- Request first seen at cycle T with N wait states:
  - `waitrequest` is high at T..T+N-1 and low at T+N.
  - Completion is at T+N; the write takes effect at the end of T+N.
  - For reads, `readdata` is valid during T+N.
- Back-to-back: a request still asserted at T+N+1 is a new transfer, starting at T+N+1 in IDLE.
- `waitrequest` is combinational from state and (`read` | `write`). It is low in IDLE with no request.
- Reset values:
  - `waitrequest` = 1 while `nreset` is low.
  - `readdata` = 0, `irq` = 0, FSM = IDLE.
  - mtime = 0, mtimecmp = 64'hFFFFFFFF_FFFFFFFF.
- RAM contents are not reset.
- Reset mid-transfer: the transfer is abandoned, no RAM or timer write occurs, and the block returns to IDLE. The master reissues the request after reset.
- Read of mtime returns the value before the current edge's increment.

## Test plan
- RD_WAIT=1, WR_WAIT=0. Write 32'hDEADBEEF to 0x100 with be=4'hF, then read 0x100:
  - the write completes with `waitrequest` never high;
  - the read shows `waitrequest` high for 1 cycle, then `readdata` = 32'hDEADBEEF.
- Byte enables: write 32'h11223344 with be=4'b0101 over 32'hDEADBEEF, then read back -> 32'hDE22BE44.
- RD_WAIT=3, WR_WAIT=2 with back-to-back reads of 0x0 and 0x4 held asserted -> `waitrequest` pattern 1,1,1,0,1,1,1,0, with the correct data in each 0 cycle.
- Timer:
  - after reset, write mtimecmp = 20 (hi word = 0) -> `irq` rises exactly one cycle after mtime reaches 20;
  - write mtimecmp hi = 32'hFFFFFFFF -> `irq` falls the following cycle.
- Alias and decode, ADDR_WIDTH=12: write 0x00004000 -> readable at 0x0. A write to `TIMER_BASE`+0 = 0 resets mtime and does not touch RAM word 0.
- Pull `nreset` low during a write's WAIT state -> `waitrequest` = 1 and `irq` = 0 immediately; the target RAM word is unchanged after reset.

Source files
------------

// File: rtl/vproc_mem_responder.sv
// Memory-mapped responder for the VProc RISC-V wrapper: byte-enabled word RAM,
// programmable wait states and a 64-bit mtime/mtimecmp timer driving irq.
module vproc_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_WAIT    = 1,
    parameter int unsigned WR_WAIT    = 0,
    parameter logic [31:0] TIMER_BASE = 32'hAFFFFFE0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] RD_N = 4'(RD_WAIT);
    localparam logic [3:0] WR_N = 4'(WR_WAIT);

    logic [31:0] mem [2**ADDR_WIDTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    logic                  req;
    logic [3:0]            n_wait;
    logic                  tmr_sel;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  fetch;
    logic                  wait_c;
    logic                  commit;
    logic [31:0]           rdata_mux;
    logic                  unused_addr_lsb;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign req             = read | write;
    assign n_wait          = write ? WR_N : RD_N;
    assign tmr_sel         = (address[31:4] == TIMER_BASE[31:4]);
    assign word_idx        = address[ADDR_WIDTH+1:2];
    assign unused_addr_lsb = ^address[1:0];

    // The IDLE cycle that first sees the request counts as the first wait
    // cycle, so WAIT only covers the remaining N-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_c  = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && (n_wait != 4'd0)) begin
                    wait_c = 1'b1;
                    cnt_d  = n_wait - 4'd1;
                    if (n_wait == 4'd1) begin
                        state_d = DONE;
                        fetch   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                wait_c = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    fetch   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign waitrequest = ~nreset | wait_c;
    assign commit      = write & ~waitrequest;

    always_comb begin
        rdata_mux = mem[word_idx];
        if (tmr_sel) begin
            case (address[3:2])
                2'd0:    rdata_mux = mtime_q[31:0];
                2'd1:    rdata_mux = mtime_q[63:32];
                2'd2:    rdata_mux = mtimecmp_q[31:0];
                default: rdata_mux = mtimecmp_q[63:32];
            endcase
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (fetch && read && !write) readdata_d = rdata_mux;
    end

    // A write landing on an mtime word replaces it and skips that cycle's tick.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        irq_d      = (mtime_q >= mtimecmp_q);
        if (commit && tmr_sel) begin
            case (address[3:2])
                2'd0:    mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], writedata, byteenable)};
                2'd1:    mtime_d = {be_merge(mtime_q[63:32], writedata, byteenable), mtime_q[31:0]};
                2'd2:    mtimecmp_d = {mtimecmp_q[63:32], be_merge(mtimecmp_q[31:0], writedata, byteenable)};
                default: mtimecmp_d = {be_merge(mtimecmp_q[63:32], writedata, byteenable), mtimecmp_q[31:0]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !tmr_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) mem[word_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Bench for vproc_mem_responder: two instances (1/0 and 3/2 wait states)
// checked every cycle against a transaction-level memory and timer model.
module tb_vproc_mem_responder;

    localparam logic [31:0] TBASE = 32'hAFFFFFE0;
    localparam int RDW [2] = '{1, 3};
    localparam int WRW [2] = '{0, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset    [2];
    logic [31:0] address   [2];
    logic        write     [2];
    logic        read      [2];
    logic [31:0] writedata [2];
    logic [3:0]  be        [2];

    logic [31:0] readdata_a, readdata_b;
    logic        waitreq_a, waitreq_b, irq_a, irq_b;

    vproc_mem_responder #(.ADDR_WIDTH(12), .RD_WAIT(1), .WR_WAIT(0), .TIMER_BASE(TBASE)) dut_a (
        .clk(clk), .nreset(nreset[0]), .address(address[0]), .write(write[0]),
        .writedata(writedata[0]), .byteenable(be[0]), .read(read[0]),
        .readdata(readdata_a), .waitrequest(waitreq_a), .irq(irq_a));

    vproc_mem_responder #(.ADDR_WIDTH(12), .RD_WAIT(3), .WR_WAIT(2), .TIMER_BASE(TBASE)) dut_b (
        .clk(clk), .nreset(nreset[1]), .address(address[1]), .write(write[1]),
        .writedata(writedata[1]), .byteenable(be[1]), .read(read[1]),
        .readdata(readdata_b), .waitrequest(waitreq_b), .irq(irq_b));

    // Expectations for the current cycle, set by the stimulus, consumed by the compare process
    bit          exp_wr_en [2];
    bit          exp_wr    [2];
    bit          exp_rd_en [2];
    logic [31:0] exp_rd    [2];
    bit          lit_rd_en [2];
    logic [31:0] lit_rd    [2];
    bit          lit_irq_en[2];
    bit          lit_irq   [2];

    // Model inputs: a write the model must apply at the next rising edge
    bit          mdl_we   [2];
    logic [31:0] mdl_addr [2];
    logic [31:0] mdl_data [2];
    logic [3:0]  mdl_be   [2];

    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    bit          m_irq   [2];
    logic [31:0] m_mem   [2][4096];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_read(input int id, input logic [31:0] a);
        if (a[31:4] == TBASE[31:4]) begin
            case (a[3:2])
                2'd0:    return m_mtime[id][31:0];
                2'd1:    return m_mtime[id][63:32];
                2'd2:    return m_cmp[id][31:0];
                default: return m_cmp[id][63:32];
            endcase
        end
        return m_mem[id][a[13:2]];
    endfunction

    // Timer and memory model: irq from pre-edge values, then apply the write or tick mtime
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mtime[i] = 64'd0;
            m_cmp[i]   = '1;
            m_irq[i]   = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!nreset[i]) begin
                    m_mtime[i] = 64'd0;
                    m_cmp[i]   = '1;
                    m_irq[i]   = 1'b0;
                end else begin
                    bit inc;
                    inc      = 1'b1;
                    m_irq[i] = (m_mtime[i] >= m_cmp[i]);
                    if (mdl_we[i]) begin
                        if (mdl_addr[i][31:4] == TBASE[31:4]) begin
                            case (mdl_addr[i][3:2])
                                2'd0: begin m_mtime[i][31:0]  = merge(m_mtime[i][31:0], mdl_data[i], mdl_be[i]); inc = 1'b0; end
                                2'd1: begin m_mtime[i][63:32] = merge(m_mtime[i][63:32], mdl_data[i], mdl_be[i]); inc = 1'b0; end
                                2'd2: m_cmp[i][31:0]  = merge(m_cmp[i][31:0], mdl_data[i], mdl_be[i]);
                                default: m_cmp[i][63:32] = merge(m_cmp[i][63:32], mdl_data[i], mdl_be[i]);
                            endcase
                        end else begin
                            m_mem[i][mdl_addr[i][13:2]] = merge(m_mem[i][mdl_addr[i][13:2]], mdl_data[i], mdl_be[i]);
                        end
                    end
                    if (inc) m_mtime[i] = m_mtime[i] + 64'd1;
                end
            end
        end
    end

    function automatic logic [31:0] get_rd(input int id);
        return (id == 0) ? readdata_a : readdata_b;
    endfunction
    function automatic logic get_wr(input int id);
        return (id == 0) ? waitreq_a : waitreq_b;
    endfunction
    function automatic logic get_irq(input int id);
        return (id == 0) ? irq_a : irq_b;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, id, $time, act, expv);
        end
    endtask

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (exp_wr_en[i])  chk("waitrequest", i, {31'd0, get_wr(i)}, {31'd0, exp_wr[i]});
                if (exp_rd_en[i])  chk("readdata_model", i, get_rd(i), exp_rd[i]);
                if (lit_rd_en[i])  chk("readdata_literal", i, get_rd(i), lit_rd[i]);
                if (nreset[i])     chk("irq_model", i, {31'd0, get_irq(i)}, {31'd0, m_irq[i]});
                if (lit_irq_en[i]) chk("irq_literal", i, {31'd0, get_irq(i)}, {31'd0, lit_irq[i]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_wr_en[i]  = 1'b0;
            exp_rd_en[i]  = 1'b0;
            lit_rd_en[i]  = 1'b0;
            lit_irq_en[i] = 1'b0;
            mdl_we[i]     = 1'b0;
        end
    endtask

    // One transfer on instance id; waitrequest is expected high for N cycles, then low
    task automatic xfer(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] bev, input bit lit_en, input logic [31:0] lit);
        int n;
        logic [31:0] snap;
        n = wr ? WRW[id] : RDW[id];
        snap = 32'd0;
        address[id] = addr; write[id] = wr; read[id] = !wr;
        writedata[id] = data; be[id] = bev;
        for (int k = 0; k <= n; k++) begin
            exp_wr_en[id] = 1'b1;
            exp_wr[id]    = (k < n);
            if (!wr && k == n - 1) snap = mdl_read(id, addr);
            if (k == n) begin
                if (wr) begin
                    mdl_we[id] = 1'b1; mdl_addr[id] = addr; mdl_data[id] = data; mdl_be[id] = bev;
                end else begin
                    exp_rd_en[id] = 1'b1; exp_rd[id] = snap;
                    lit_rd_en[id] = lit_en; lit_rd[id] = lit;
                end
            end
            tick();
        end
        write[id] = 1'b0; read[id] = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        for (int i = 0; i < 2; i++) begin
            nreset[i] = 1'b0; address[i] = 32'd0; write[i] = 1'b0; read[i] = 1'b0;
            writedata[i] = 32'd0; be[i] = 4'd0;
            exp_wr_en[i] = 1'b0; exp_wr[i] = 1'b0; exp_rd_en[i] = 1'b0; exp_rd[i] = 32'd0;
            lit_rd_en[i] = 1'b0; lit_rd[i] = 32'd0; lit_irq_en[i] = 1'b0; lit_irq[i] = 1'b0;
            mdl_we[i] = 1'b0; mdl_addr[i] = 32'd0; mdl_data[i] = 32'd0; mdl_be[i] = 4'd0;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            exp_wr_en[i] = 1'b1; exp_wr[i] = 1'b1;
            lit_rd_en[i] = 1'b1; lit_rd[i] = 32'd0;
            lit_irq_en[i] = 1'b1; lit_irq[i] = 1'b0;
        end
        tick();
        nreset[0] = 1'b1;
        nreset[1] = 1'b1;

        // Cycle 0 after release: mtimecmp = 20, then irq rises in cycle 21
        xfer(0, 1'b1, TBASE + 32'd8,  32'd20, 4'hF, 1'b0, 32'd0);
        xfer(0, 1'b1, TBASE + 32'd12, 32'd0,  4'hF, 1'b0, 32'd0);
        for (int c = 2; c < 26; c++) begin
            lit_irq_en[0] = 1'b1; lit_irq[0] = (c >= 21);
            exp_wr_en[0]  = 1'b1; exp_wr[0]  = 1'b0;
            tick();
        end
        lit_irq_en[0] = 1'b1; lit_irq[0] = 1'b1;
        xfer(0, 1'b1, TBASE + 32'd12, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0);
        lit_irq_en[0] = 1'b1; lit_irq[0] = 1'b1;
        tick();
        lit_irq_en[0] = 1'b1; lit_irq[0] = 1'b0;
        tick();

        // RAM, byte enables, alias and timer decode on the 1/0 instance
        xfer(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'h100, 32'd0, 4'hF, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h100, 32'h11223344, 4'b0101, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'h100, 32'd0, 4'h0, 1'b1, 32'hDE22BE44);
        xfer(0, 1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'h0, 32'd0, 4'hF, 1'b1, 32'hCAFEF00D);
        xfer(0, 1'b1, TBASE, 32'd0, 4'hF, 1'b0, 32'd0);
        xfer(0, 1'b0, TBASE, 32'd0, 4'hF, 1'b1, 32'd0);
        xfer(0, 1'b0, 32'h0, 32'd0, 4'hF, 1'b1, 32'hCAFEF00D);
        xfer(0, 1'b0, TBASE + 32'd8, 32'd0, 4'hF, 1'b1, 32'd20);
        xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 1'b0, 32'd0);
        xfer(0, 1'b0, 32'h100, 32'd0, 4'hF, 1'b1, 32'hDE22BE44);

        // Concurrent read and write: write wins, readdata keeps its old value
        address[0] = 32'h200; write[0] = 1'b1; read[0] = 1'b1;
        writedata[0] = 32'h00000077; be[0] = 4'hF;
        exp_wr_en[0] = 1'b1; exp_wr[0] = 1'b0;
        mdl_we[0] = 1'b1; mdl_addr[0] = 32'h200; mdl_data[0] = 32'h77; mdl_be[0] = 4'hF;
        tick();
        write[0] = 1'b0; read[0] = 1'b0;
        lit_rd_en[0] = 1'b1; lit_rd[0] = 32'hDE22BE44;
        tick();
        xfer(0, 1'b0, 32'h200, 32'd0, 4'hF, 1'b1, 32'h00000077);

        // Back-to-back reads on the 3/2 instance with the request held high
        xfer(1, 1'b1, 32'h0, 32'hA5A50001, 4'hF, 1'b0, 32'd0);
        xfer(1, 1'b1, 32'h4, 32'h5A5A0002, 4'hF, 1'b0, 32'd0);
        pat = 8'b1110_1110;
        address[1] = 32'h0; read[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) address[1] = 32'h4;
            exp_wr_en[1] = 1'b1; exp_wr[1] = pat[7-k];
            if (k == 3) begin lit_rd_en[1] = 1'b1; lit_rd[1] = 32'hA5A50001; end
            if (k == 7) begin lit_rd_en[1] = 1'b1; lit_rd[1] = 32'h5A5A0002; end
            tick();
        end
        read[1] = 1'b0;

        // Reset during a write's WAIT state abandons the write
        xfer(1, 1'b1, TBASE + 32'd8,  32'd0, 4'hF, 1'b0, 32'd0);
        xfer(1, 1'b1, TBASE + 32'd12, 32'd0, 4'hF, 1'b0, 32'd0);
        xfer(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'd0);
        tick();
        address[1] = 32'h40; write[1] = 1'b1; writedata[1] = 32'hFFFFFFFF; be[1] = 4'hF;
        exp_wr_en[1] = 1'b1; exp_wr[1] = 1'b1;
        lit_irq_en[1] = 1'b1; lit_irq[1] = 1'b1;
        tick();
        nreset[1] = 1'b0;
        exp_wr_en[1] = 1'b1; exp_wr[1] = 1'b1;
        lit_irq_en[1] = 1'b1; lit_irq[1] = 1'b0;
        tick();
        write[1] = 1'b0;
        exp_wr_en[1] = 1'b1; exp_wr[1] = 1'b1;
        tick();
        nreset[1] = 1'b1;
        tick();
        xfer(1, 1'b0, 32'h40, 32'd0, 4'hF, 1'b1, 32'h12345678);
        xfer(1, 1'b0, TBASE + 32'd12, 32'd0, 4'hF, 1'b1, 32'hFFFFFFFF);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
